team_06_serial_adc_rx: RTL and testbench

Parametrised serial ADC receiver that generates its own bit clock from clk and deserialises DATA_W-bit words from a single serial line. Words arrive interleaved over NUM_CH channels, one channel per frame, and each word is tagged with its channel index. Completed words are buffered in a FIFO and drained through a valid/ready handshake. It sits between the external ADC pins and the downstream audio/DSP datapath. Compared with the fixed 8-bit receiver, it adds configurable width and bit order, multi-channel framing, buffering, backpressure and overrun reporting.

---
 rtl/team_06_serial_adc_rx.sv | 168 ++++++++++++++++
 tb/tb_team_06_serial_adc_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_serial_adc_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | team_06_serial_adc_rx: self-clocked multi-channel serial ADC receiver     |
// | with a first-word-fall-through output FIFO and overrun reporting.         |
// | Optional TEAM_06_ADC_RX_DROP_CNT_EN adds an 8-bit saturating drop_count.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module team_06_serial_adc_rx #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 4,
    parameter int NUM_CH     = 2,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              adc_serial_in,
    output logic              sclk,
    output logic [CH_W-1:0]   ch_sel,
    output logic              frame_done,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overrun,
    input  logic              clr_overrun
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic              sclk_prev;
    logic [BIT_W-1:0]  bit_cnt;
    logic              adv_pending;
    // Only the DATA_W-1 earlier bits are stored; the current bit completes the word.
    logic [DATA_W-2:0] shift;
    logic [DATA_W-2:0] shift_next;
    logic [DATA_W-1:0] word;
    logic              rise;
    logic              fall;
    logic              push;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;

    assign rise = sclk & ~sclk_prev;
    assign fall = ~sclk & sclk_prev;
    assign push = en & rise & (bit_cnt == BIT_W'(DATA_W - 1));

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign word       = {shift, adc_serial_in};
            assign shift_next = word[DATA_W-2:0];
        end else begin : g_lsb_first
            assign word       = {adc_serial_in, shift};
            assign shift_next = word[DATA_W-1:1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            sclk        <= 1'b0;
            sclk_prev   <= 1'b0;
            bit_cnt     <= '0;
            shift       <= '0;
            ch_sel      <= '0;
            adv_pending <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            sclk_prev  <= sclk;
            frame_done <= push;
            if (!en) begin
                div_cnt     <= '0;
                sclk        <= 1'b0;
                bit_cnt     <= '0;
                ch_sel      <= '0;
                adv_pending <= 1'b0;
            end else begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (rise) begin
                    shift   <= shift_next;
                    bit_cnt <= push ? '0 : bit_cnt + 1'b1;
                end
                // Channel moves on the falling edge after a word, so the tag
                // pushed with the word is the channel it was framed under.
                if (push) begin
                    adv_pending <= 1'b1;
                end else if (fall && adv_pending) begin
                    adv_pending <= 1'b0;
                    ch_sel      <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
                end
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ch    = out_valid ? mem_ch[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= word;
            mem_ch[wr_ptr]   <= ch_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (clr_overrun) begin
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_team_06_serial_adc_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_team_06_serial_adc_rx: drives MSB-first and LSB-first receivers from   |
// | one serial stream and checks both against a word-level reference model.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_team_06_serial_adc_rx;

    localparam int DATA_W     = 8;
    localparam int CLK_DIV    = 2;
    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = 1;
    localparam int CNT_W      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic adc_serial_in = 1'b0;
    logic out_ready = 1'b0;
    logic clr_overrun = 1'b0;

    logic              sclk_m, sclk_l, fd_m, fd_l, valid_m, valid_l, ovr_m, ovr_l;
    logic [CH_W-1:0]   ch_sel_m, ch_sel_l, out_ch_m, out_ch_l;
    logic [DATA_W-1:0] data_m, data_l;
    logic [CNT_W-1:0]  cnt_m, cnt_l;
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
    logic [7:0]        dc_m, dc_l;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    team_06_serial_adc_rx #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH),
        .MSB_FIRST(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_m (
        .clk(clk), .rst(rst), .en(en), .adc_serial_in(adc_serial_in),
        .sclk(sclk_m), .ch_sel(ch_sel_m), .frame_done(fd_m),
        .out_data(data_m), .out_ch(out_ch_m), .out_valid(valid_m),
        .out_ready(out_ready), .fifo_count(cnt_m), .overrun(ovr_m),
        .clr_overrun(clr_overrun)
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
        , .drop_count(dc_m)
`endif
    );

    team_06_serial_adc_rx #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH),
        .MSB_FIRST(0), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_l (
        .clk(clk), .rst(rst), .en(en), .adc_serial_in(adc_serial_in),
        .sclk(sclk_l), .ch_sel(ch_sel_l), .frame_done(fd_l),
        .out_data(data_l), .out_ch(out_ch_l), .out_valid(valid_l),
        .out_ready(out_ready), .fifo_count(cnt_l), .overrun(ovr_l),
        .clr_overrun(clr_overrun)
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
        , .drop_count(dc_l)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bit clock from enabled-cycle count, words from sampled bits.
    typedef struct {
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] l;
        logic [CH_W-1:0]   ch;
    } entry_t;

    entry_t            mq[$];
    entry_t            me;
    int                m_n = 0;
    int                m_bits = 0;
    int                m_wcnt = 0;
    int                m_samples = 0;
    int                m_drop = 0;
    logic              m_ovr = 1'b0;
    logic              m_fd = 1'b0;
    logic [DATA_W-1:0] m_seq;
    bit                mp_pop, mp_push, mp_drop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_n = 0; m_bits = 0; m_wcnt = 0; m_drop = 0;
            m_ovr = 1'b0; m_fd = 1'b0;
        end else begin
            mp_pop  = (mq.size() != 0) && out_ready;
            mp_push = 1'b0;
            if (en) begin
                if (m_n % (2 * CLK_DIV) == CLK_DIV) begin
                    m_seq[m_bits] = adc_serial_in;
                    m_bits++;
                    m_samples++;
                    if (m_bits == DATA_W) begin
                        mp_push = 1'b1;
                        me.m = '0;
                        me.l = '0;
                        for (int i = 0; i < DATA_W; i++) begin
                            me.m = {me.m[DATA_W-2:0], m_seq[i]};
                            me.l[i] = m_seq[i];
                        end
                        me.ch = CH_W'(m_wcnt % NUM_CH);
                        m_wcnt++;
                        m_bits = 0;
                    end
                end
                m_n++;
            end else begin
                m_n = 0; m_bits = 0; m_wcnt = 0;
            end
            mp_drop = mp_push && (mq.size() == FIFO_DEPTH) && !mp_pop;
            if (mp_pop) void'(mq.pop_front());
            if (mp_push && !mp_drop) mq.push_back(me);
            if (clr_overrun) begin
                m_ovr  = mp_drop;
                m_drop = mp_drop ? 1 : 0;
            end else if (mp_drop) begin
                m_ovr = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            m_fd = mp_push;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("sclk_m", sclk_m, (m_n / CLK_DIV) % 2);
            chk("sclk_l", sclk_l, (m_n / CLK_DIV) % 2);
            chk("frame_done_m", fd_m, m_fd);
            chk("frame_done_l", fd_l, m_fd);
            chk("out_valid_m", valid_m, mq.size() != 0);
            chk("out_valid_l", valid_l, mq.size() != 0);
            chk("fifo_count_m", cnt_m, mq.size());
            chk("fifo_count_l", cnt_l, mq.size());
            chk("overrun_m", ovr_m, m_ovr);
            chk("overrun_l", ovr_l, m_ovr);
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
            chk("drop_count_m", dc_m, m_drop);
            chk("drop_count_l", dc_l, m_drop);
`endif
            if (mq.size() != 0) begin
                chk("out_data_m", data_m, mq[0].m);
                chk("out_data_l", data_l, mq[0].l);
                chk("out_ch_m", out_ch_m, mq[0].ch);
                chk("out_ch_l", out_ch_l, mq[0].ch);
            end
        end
    end

    logic [DATA_W-1:0] got_m[$];
    logic [DATA_W-1:0] got_l[$];
    logic [CH_W-1:0]   got_ch[$];

    always @(posedge clk) begin
        if (!rst && valid_m && out_ready) begin
            got_m.push_back(data_m);
            got_l.push_back(data_l);
            got_ch.push_back(out_ch_m);
        end
    end

    // Serial bits go out in transmission order (value MSB first); each is held
    // until the model has consumed it on a rising bit clock.
    task automatic send_bits(input logic [DATA_W-1:0] val, input int nbits, input int exp_ch);
        int s0;
        int k;
        for (int i = 0; i < nbits; i++) begin
            adc_serial_in = val[DATA_W-1-i];
            s0 = m_samples;
            k = 0;
            while (m_samples == s0 && k < 64) begin
                @(negedge clk);
                k++;
            end
            chk("sample_timeout", (m_samples == s0) ? 1 : 0, 0);
            if (i == 0 && exp_ch >= 0) begin
                chk("ch_sel_m", ch_sel_m, exp_ch);
                chk("ch_sel_l", ch_sel_l, exp_ch);
            end
        end
    endtask

    task automatic ready_at_push();
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if ((m_n % (2 * CLK_DIV) == CLK_DIV) && (m_bits == DATA_W - 1)) begin
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("push_window_found", found, 1);
    endtask

    task automatic clear_got();
        got_m.delete();
        got_l.delete();
        got_ch.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", valid_m, 0);
        chk("rst_fifo_count", cnt_m, 0);
        chk("rst_sclk", sclk_m, 0);
        chk("rst_ch_sel", ch_sel_m, 0);
        chk("rst_overrun", ovr_m, 0);

        // Basic framing and both bit orders
        out_ready = 1'b1;
        en = 1'b1;
        send_bits(8'hA5, 8, 0);
        chk("latency_valid", valid_m, 1);
        chk("latency_frame_done", fd_m, 1);
        send_bits(8'h3C, 8, 1);
        send_bits(8'h01, 8, 0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("p1_count", got_m.size(), 3);
        chk("p1_w0_m", got_m[0], 8'hA5);
        chk("p1_w0_ch", got_ch[0], 0);
        chk("p1_w1_m", got_m[1], 8'h3C);
        chk("p1_w1_ch", got_ch[1], 1);
        chk("p1_w2_m", got_m[2], 8'h01);
        chk("p1_w2_l", got_l[2], 8'h80);

        // Overrun with consumer stalled
        clear_got();
        out_ready = 1'b0;
        en = 1'b1;
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 8, 1);
        send_bits(8'h33, 8, 0);
        send_bits(8'h44, 8, 1);
        send_bits(8'h55, 8, 0);
        en = 1'b0;
        @(negedge clk);
        chk("ovr_fifo_count", cnt_m, 4);
        chk("ovr_flag", ovr_m, 1);
`ifdef TEAM_06_ADC_RX_DROP_CNT_EN
        chk("ovr_drop_count", dc_m, 1);
`endif
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        chk("ovr_pop_count", got_m.size(), 4);
        chk("ovr_pop0", got_m[0], 8'h11);
        chk("ovr_pop1", got_m[1], 8'h22);
        chk("ovr_pop2", got_m[2], 8'h33);
        chk("ovr_pop3", got_m[3], 8'h44);
        chk("ovr_pop0_l", got_l[0], 8'h88);
        chk("ovr_sticky", ovr_m, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("ovr_cleared", ovr_m, 0);

        // Full FIFO with push and pop on the same cycle
        clear_got();
        en = 1'b1;
        send_bits(8'h81, 8, 0);
        send_bits(8'h42, 8, 1);
        send_bits(8'h24, 8, 0);
        send_bits(8'h18, 8, 1);
        fork
            send_bits(8'h99, 8, 0);
            ready_at_push();
        join
        en = 1'b0;
        @(negedge clk);
        chk("full_pp_count", cnt_m, 4);
        chk("full_pp_overrun", ovr_m, 0);
        chk("full_pp_popped", got_m[0], 8'h81);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("full_pp_total", got_m.size(), 5);
        chk("full_pp_last", got_m[4], 8'h99);

        // Disable mid-word discards the partial bits
        clear_got();
        en = 1'b1;
        send_bits(8'hE0, 3, -1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        send_bits(8'h5A, 8, 0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_word_count", got_m.size(), 1);
        chk("en_word", got_m[0], 8'h5A);
        chk("en_word_ch", got_ch[0], 0);

        // Reset mid-word with words queued
        out_ready = 1'b0;
        en = 1'b1;
        send_bits(8'h12, 8, 0);
        send_bits(8'h34, 8, 1);
        send_bits(8'h56, 8, 0);
        send_bits(8'hFF, 3, 1);
        chk("pre_rst_count", cnt_m, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", valid_m, 0);
        chk("mid_rst_count", cnt_m, 0);
        chk("mid_rst_sclk", sclk_m, 0);
        chk("mid_rst_ch_sel", ch_sel_m, 0);
        chk("mid_rst_overrun", ovr_m, 0);
        rst = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
